// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round sequencer and its watchdog.
package aes_pkg;

  localparam int AES_MAX_ROUNDS = 14;
  localparam int ROUND_W        = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARK,
    S_SUB,
    S_SHR,
    S_MIX,
    S_FIN,
    S_ERR
  } seq_state_t;

  typedef enum logic [1:0] {
    STG_ARK,
    STG_SUB,
    STG_SHR,
    STG_MIX
  } aes_stage_t;

  function automatic logic is_stage_state(seq_state_t s);
    return (s inside {S_ARK, S_SUB, S_SHR, S_MIX});
  endfunction

  function automatic aes_stage_t stage_of(seq_state_t s);
    case (s)
      S_SUB:   return STG_SUB;
      S_SHR:   return STG_SHR;
      S_MIX:   return STG_MIX;
      default: return STG_ARK;
    endcase
  endfunction

  // Bit order matches {mix, shr, sub, ark}.
  function automatic logic [3:0] stage_onehot(aes_stage_t st);
    return 4'b0001 << st;
  endfunction

endpackage

// File: rtl/aes_stage_watchdog.sv
// Per-stage watchdog: down-counter reloaded on every go pulse, flags a stage
// that has not acked within TIMEOUT_CYCLES. Only built with AES_SEQ_WATCHDOG_EN.
module aes_stage_watchdog #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic active,
  output logic timeout
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES);
  // Loaded on the go cycle; reaching zero marks the last cycle the stage may ack.
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= LOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign timeout = active && !clear && (cnt_q == '0);

endmodule

// File: rtl/aes_round_sequencer.sv
// Steps AddRoundKey/SubBytes/ShiftRows/MixColumns through the AES-128 round
// schedule. Optional stage watchdog enabled by defining AES_SEQ_WATCHDOG_EN.
//
//   state  | meaning
//   IDLE   | waiting for start
//   ARK    | AddRoundKey active
//   SUB    | SubBytes active
//   SHR    | ShiftRows active
//   MIX    | MixColumns active (skipped in the final round)
//   FIN    | one-cycle done pulse
//   ERR    | stage timed out, round frozen until start/abort
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS     = 10,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       ark_go,
  output logic       sub_go,
  output logic       shr_go,
  output logic       mix_go,
  input  logic       ark_ack,
  input  logic       sub_ack,
  input  logic       shr_ack,
  input  logic       mix_ack,
  output logic [3:0] round,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

  seq_state_t         state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [3:0]         go_q, go_d;
  logic [3:0]         ack_vec;
  logic               stage_active;
  logic               ack_ok;
  logic               wd_timeout;
  aes_stage_t         cur_stage;

  assign ack_vec      = {mix_ack, shr_ack, sub_ack, ark_ack};
  assign stage_active = is_stage_state(state_q);
  assign cur_stage    = stage_of(state_q);
  // Only the active stage's ack counts, and never in the cycle its go is out.
  assign ack_ok       = stage_active && ack_vec[cur_stage] && !go_q[cur_stage];

`ifdef AES_SEQ_WATCHDOG_EN
  aes_stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (|go_q),
    .active (stage_active),
    .timeout(wd_timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wd_timeout         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    if (abort) begin
      state_d = S_IDLE;
      round_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (start) begin
            state_d = S_ARK;
            round_d = '0;
          end
        end
        S_ARK: begin
          if (ack_ok) begin
            if (round_q == LAST_ROUND) begin
              state_d = S_FIN;
            end else begin
              state_d = S_SUB;
              round_d = round_q + ROUND_W'(1);
            end
          end else if (wd_timeout) begin
            state_d = S_ERR;
          end
        end
        S_SUB: begin
          if (ack_ok)          state_d = S_SHR;
          else if (wd_timeout) state_d = S_ERR;
        end
        S_SHR: begin
          if (ack_ok)          state_d = (round_q == LAST_ROUND) ? S_ARK : S_MIX;
          else if (wd_timeout) state_d = S_ERR;
        end
        S_MIX: begin
          if (ack_ok)          state_d = S_ARK;
          else if (wd_timeout) state_d = S_ERR;
        end
        S_FIN: begin
          state_d = S_IDLE;
          round_d = '0;
        end
        default: begin
          state_d = S_IDLE;
          round_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    go_d = '0;
    if ((state_d != state_q) && is_stage_state(state_d)) begin
      go_d = stage_onehot(stage_of(state_d));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      round_q <= '0;
      go_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      go_q    <= go_d;
    end
  end

  assign ark_go = go_q[0];
  assign sub_go = go_q[1];
  assign shr_go = go_q[2];
  assign mix_go = go_q[3];
  assign round  = round_q;
  assign busy   = stage_active || (state_q == S_FIN);
  assign done   = (state_q == S_FIN);
  assign err    = (state_q == S_ERR);

endmodule
